mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
Memory-access sequencer directly downstream of the 4:1 instruction/data address mux in the multicycle MIPS datapath. It accepts the selected 32-bit address plus an access request from the control unit and drives a word-wide synchronous memory with fixed read latency. It performs byte, halfword and word loads with sign or zero extension, and byte/halfword stores by read-modify-write.
Byte order is little-endian: byte lane k = bits [8k+7:8k], selected by addr[1:0].

Parameters:
MEM_LATENCY, 1, cycles from the mem_rd cycle to valid mem_rdata; legal range 1..7

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  1  access request, sampled in IDLE only
we  input  1  1 = store, 0 = load
size  input  2  00 byte, 01 half, 10 word, 11 treated as word
sext  input  1  loads: 1 = sign-extend, 0 = zero-extend
addr  input  32  byte address from the IorD mux
wdata  input  32  store data, right-aligned for byte/half
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
rdata  output  32  extended load result, held until next load completes
misaligned  output  1  pulses with done on an alignment fault
mem_addr  output  32  word address to memory, {addr_q[31:2],2'b00}
mem_rd  output  1  one-cycle memory read strobe
mem_wr  output  1  one-cycle memory write strobe
mem_wdata  output  32  word written to memory
mem_rdata  input  32  memory read data

Behaviour:
- Reset, asynchronous: state=IDLE, busy=0, done=0, misaligned=0, rdata=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0. Reset mid-operation aborts the access. No done pulse is produced and no write is issued.
- All outputs are registered.
- States: IDLE, RD, WAIT, WR, FIN.
- IDLE:
  - On req=1, latch addr, we, size, sext and wdata.
  - Next state:
    - Word store goes to WR.
    - Any load or sub-word store goes to RD.
    - An alignment fault (see Optional Feature) goes to FIN.
- RD: mem_rd=1 for exactly one cycle, mem_addr valid. Load the latency counter with MEM_LATENCY, then go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When it reaches 0, sample mem_rdata. This is the cycle that is MEM_LATENCY cycles after the RD cycle.
  - Load: extract the lane, extend it into rdata, then go to FIN.
  - Sub-word store: merge wdata[7:0] or wdata[15:0] into the selected lane of the read word. That lane is the byte at addr[1:0], or the half at addr[1] (1 = bits 31:16). Place the merged word on mem_wdata, then go to WR.
- WR: mem_wr=1 for exactly one cycle with mem_addr and mem_wdata valid. Word store writes wdata unchanged. Next state is FIN.
- FIN: done=1 for one cycle, then return to IDLE. The next req is accepted in the cycle after FIN.
- Latency from the req cycle to the done cycle:
  - Load: MEM_LATENCY+2.
  - Word store: 2.
  - Sub-word store: MEM_LATENCY+3.
- Other rules:
  - req while busy=1 is ignored (not queued).
  - Input changes after acceptance have no effect.
  - mem_rd and mem_wr are never high in the same cycle.
  - Stores leave rdata unchanged.
  - size=11 behaves identically to size=10.

Optional Feature:
Macro MEM_ACCESS_ALIGN_TRAP_EN.
- Defined:
  - A half access with addr[0]=1, or a word access with addr[1:0]!=0, is a fault.
  - On a fault, IDLE goes straight to FIN with no mem_rd/mem_wr. done and misaligned pulse together, rdata is unchanged, and latency is 2.
- Undefined:
  - Half accesses ignore addr[0] and word accesses ignore addr[1:0].
  - misaligned is tied to 0.
  - No access is ever trapped.

Test Plan:
- Reset, then word store of 0xDEADBEEF to 0x100. Expect mem_wr for one cycle at mem_addr 0x100 with mem_wdata 0xDEADBEEF, then done 2 cycles after req, with no mem_rd.
- MEM_LATENCY=3, memory word at 0x100 = 0x80FF7F01:
  - lb at 0x102 with sext=1 gives rdata 0xFFFFFFFF.
  - lbu at 0x103 gives 0x00000080.
  - lh at 0x102 with sext=1 gives 0xFFFF80FF.
  - Each done arrives 5 cycles after req.
- sb of wdata 0x000000AA to 0x101 over memory word 0x11223344. Expect one mem_rd, then mem_wr with mem_wdata 0x1122AA44, and done MEM_LATENCY+3 cycles after req.
- Hold req high throughout a load. Expect no second mem_rd before FIN; the second access starts the cycle after done.
- Assert reset during WAIT of a sub-word store. Expect mem_wr never asserted, done=0, rdata=0, and busy=0 immediately.
- With MEM_ACCESS_ALIGN_TRAP_EN defined, lw at 0x102 gives done=misaligned=1 two cycles after req, no memory strobes, rdata unchanged. Without the macro, the same access reads word 0x100 and misaligned stays 0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-access sequencer for the multicycle MIPS datapath: byte/half/word loads with extension,
// sub-word stores by read-modify-write. Optional alignment trap: define MEM_ACCESS_ALIGN_TRAP_EN.
module mem_access_unit #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_FIN} state_t;

    localparam logic [2:0] LAT_CNT = 3'(MEM_LATENCY);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        we_q, we_d;
    logic        sext_q, sext_d;
    logic        fault_q, fault_d;

    logic        busy_d, done_d, misaligned_d, mem_rd_d, mem_wr_d;
    logic [31:0] rdata_d, mem_addr_d, mem_wdata_d;

    logic        fault;
    logic [31:0] byte_sel, half_sel, load_val, merged;

`ifdef MEM_ACCESS_ALIGN_TRAP_EN
    assign fault = (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
`else
    assign fault = 1'b0;
`endif

    // Lane extraction and store merge work on the word returned by memory.
    always_comb begin
        byte_sel = mem_rdata >> {addr_q[1:0], 3'b000};
        half_sel = mem_rdata >> {addr_q[1], 4'b0000};
        load_val = mem_rdata;
        merged   = mem_rdata;
        case (size_q)
            2'b00: begin
                load_val = {{24{sext_q & byte_sel[7]}}, byte_sel[7:0]};
                merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            2'b01: begin
                load_val = {{16{sext_q & half_sel[15]}}, half_sel[15:0]};
                merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: ;
        endcase
    end

    // NOTE: every signal gets a default before the case, so no latch can be inferred.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        size_d       = size_q;
        we_d         = we_q;
        sext_d       = sext_q;
        fault_d      = fault_q;
        done_d       = 1'b0;
        misaligned_d = 1'b0;
        mem_rd_d     = 1'b0;
        mem_wr_d     = 1'b0;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        rdata_d      = rdata;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d     = addr;
                    wdata_d    = wdata;
                    size_d     = size;
                    we_d       = we;
                    sext_d     = sext;
                    fault_d    = fault;
                    mem_addr_d = {addr[31:2], 2'b00};
                    // A trapped access idles one strobe-less cycle in WR so done lands two cycles after req.
                    if (fault) begin
                        state_d = S_WR;
                    end else if (we && size[1]) begin
                        state_d     = S_WR;
                        mem_wr_d    = 1'b1;
                        mem_wdata_d = wdata;
                    end else begin
                        state_d  = S_RD;
                        mem_rd_d = 1'b1;
                    end
                end
            end
            S_RD: begin
                cnt_d   = LAT_CNT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    if (!we_q) begin
                        rdata_d = load_val;
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        mem_wdata_d = merged;
                        mem_wr_d    = 1'b1;
                        state_d     = S_WR;
                    end
                end
            end
            S_WR: begin
                done_d       = 1'b1;
                misaligned_d = fault_q;
                state_d      = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: state and outputs update with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= '0;
            we_q       <= 1'b0;
            sext_q     <= 1'b0;
            fault_q    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            misaligned <= 1'b0;
            rdata      <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            we_q       <= we_d;
            sext_q     <= sext_d;
            fault_q    <= fault_d;
            busy       <= busy_d;
            done       <= done_d;
            misaligned <= misaligned_d;
            rdata      <= rdata_d;
            mem_rd     <= mem_rd_d;
            mem_wr     <= mem_wr_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
        end
    end

endmodule
